// File: rtl/calc_req_scheduler.sv
// calc_req_scheduler: queues calculator requests, issues one per cycle, returns tagged results in order.
// Define CALC_SCHED_STATS_EN to build the issue/response statistics counters; otherwise they read 0.
module calc_req_scheduler #(
   parameter int REQ_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int CALC_LAT  = 1,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             reset_high,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [2:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             flush_done,
   output logic [31:0]      calc_a,
   output logic [31:0]      calc_b,
   output logic [2:0]       calc_opcode,
   input  logic [32:0]      calc_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [32:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy,
   output logic [15:0]      issue_cnt,
   output logic [15:0]      rsp_cnt
);
   localparam int QW = $clog2(REQ_DEPTH);
   localparam int RW = $clog2(RSP_DEPTH);
   localparam int EW = 67 + TAG_W;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;
   logic flush_done_nxt, req_push, req_empty, issue, rsp_push, rsp_pop, all_empty;
   logic [EW-1:0] req_mem [REQ_DEPTH];
   logic [EW-1:0] head;
   logic [QW:0] req_wr, req_rd, req_count;
   logic [TAG_W+32:0] rsp_mem [RSP_DEPTH];
   logic [TAG_W+32:0] rsp_head;
   logic [RW:0] rsp_wr, rsp_rd, rsp_count;
   logic [CALC_LAT-1:0] sr_vld;
   logic [TAG_W-1:0] sr_tag [CALC_LAT];

   assign req_count  = req_wr - req_rd;
   assign req_empty  = req_count == '0;
   assign req_ready  = req_count != (QW+1)'(REQ_DEPTH) && state != DRAIN;
   assign req_push   = req_valid && req_ready;
   assign head       = req_mem[req_rd[QW-1:0]];
   // an op issues only if its result is already guaranteed a response slot
   assign issue      = !req_empty && ($countones(sr_vld) + int'(rsp_count)) < RSP_DEPTH;
   assign rsp_push   = sr_vld[CALC_LAT-1];
   assign rsp_count  = rsp_wr - rsp_rd;
   assign rsp_valid  = rsp_count != '0;
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign rsp_head   = rsp_mem[rsp_rd[RW-1:0]];
   assign rsp_result = rsp_valid ? rsp_head[TAG_W +: 33] : '0;
   assign rsp_tag    = rsp_valid ? rsp_head[TAG_W-1:0] : '0;
   assign all_empty  = req_empty && sr_vld == '0 && !rsp_valid;

   // FIFO storage and in-flight tags; validity is carried by pointers and sr_vld
   always_ff @(posedge clk) begin
      if (req_push) req_mem[req_wr[QW-1:0]] <= {req_a, req_b, req_op, req_tag};
      if (rsp_push) rsp_mem[rsp_wr[RW-1:0]] <= {calc_result, sr_tag[CALC_LAT-1]};
      sr_tag[0] <= head[TAG_W-1:0];
      for (int i = 1; i < CALC_LAT; i++) sr_tag[i] <= sr_tag[i-1];
   end

   // FIFO pointers, in-flight valid pipe and calculator input registers
   always_ff @(posedge clk or posedge reset_high) begin
      if (reset_high) begin
         req_wr      <= '0;
         req_rd      <= '0;
         rsp_wr      <= '0;
         rsp_rd      <= '0;
         sr_vld      <= '0;
         calc_a      <= '0;
         calc_b      <= '0;
         calc_opcode <= '0;
      end else begin
         if (req_push) req_wr <= req_wr + 1'b1;
         if (issue) begin
            req_rd      <= req_rd + 1'b1;
            calc_a      <= head[EW-1 -: 32];
            calc_b      <= head[EW-33 -: 32];
            calc_opcode <= head[TAG_W +: 3];
         end
         if (rsp_push) rsp_wr <= rsp_wr + 1'b1;
         if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
         sr_vld <= CALC_LAT'({sr_vld, issue});
      end
   end

`ifdef CALC_SCHED_STATS_EN
   // statistics: issues and response handshakes, free-running 16-bit wrap
   always_ff @(posedge clk or posedge reset_high) begin
      if (reset_high) begin
         issue_cnt <= '0;
         rsp_cnt   <= '0;
      end else begin
         if (issue) issue_cnt <= issue_cnt + 1'b1;
         if (rsp_pop) rsp_cnt <= rsp_cnt + 1'b1;
      end
   end
`else
   assign issue_cnt = '0;
   assign rsp_cnt   = '0;
`endif

   // state register with registered busy and flush_done
   always_ff @(posedge clk or posedge reset_high) begin
      if (reset_high) begin
         state      <= IDLE;
         busy       <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         busy       <= state_nxt != IDLE;
         flush_done <= flush_done_nxt;
      end
   end

   // next state: flush drains; IDLE only once nothing is queued, in flight or buffered
   always_comb begin
      state_nxt      = state;
      flush_done_nxt = 1'b0;
      case (state)
         IDLE:    if (req_push) state_nxt = flush ? DRAIN : RUN;
                  else flush_done_nxt = flush;
         RUN:     if (flush) state_nxt = DRAIN;
                  else if (all_empty && !req_push) state_nxt = IDLE;
         DRAIN:   if (all_empty) begin
                     state_nxt      = IDLE;
                     flush_done_nxt = 1'b1;
                  end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_calc_req_scheduler.sv
// tb_calc_req_scheduler: vector table, corner sequences and random traffic checked against a queue model.
module tb_calc_req_scheduler;
   localparam int TW        = 4;
   localparam int REQ_DEPTH = 4;
   localparam int RSP_DEPTH = 4;
   logic clk = 1'b0, reset_high = 1'b0;
   logic req_valid = 1'b0, req_ready, flush = 1'b0, flush_done, rsp_valid, rsp_ready = 1'b0, busy;
   logic [31:0] req_a = '0, req_b = '0, calc_a, calc_b;
   logic [2:0] req_op = '0, calc_opcode;
   logic [TW-1:0] req_tag = '0, rsp_tag;
   logic [32:0] calc_result, rsp_result;
   logic [15:0] issue_cnt, rsp_cnt;
   int passed = 0, total = 0, n_rsp = 0;
   int k, n0, first, last, done_at;
   logic acc, hs;
   typedef struct { logic [32:0] res; logic [TW-1:0] tag; } exp_t;
   exp_t exp_q[$];
   typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; logic [TW-1:0] tag; logic [32:0] res; } vec_t;
   vec_t vecs[6];

   calc_req_scheduler #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .CALC_LAT(1), .TAG_W(TW)) dut (
      .clk(clk), .reset_high(reset_high), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag), .flush(flush),
      .flush_done(flush_done), .calc_a(calc_a), .calc_b(calc_b), .calc_opcode(calc_opcode),
      .calc_result(calc_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy), .issue_cnt(issue_cnt), .rsp_cnt(rsp_cnt));

   always #5 clk = ~clk;

   // calculator stand-in: result valid one cycle after its inputs are registered
   function automatic logic [32:0] calc_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      return op == 3'd0 ? {1'b0, a} + {1'b0, b} : op == 3'd1 ? {1'b0, a} - {1'b0, b} : {1'b0, a ^ b};
   endfunction
   assign calc_result = calc_fn(calc_a, calc_b, calc_opcode);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // scoreboard one cycle: record accepted request, compare consumed response, advance to next negedge
   task automatic step();
      exp_t e;
      if (req_valid && req_ready) exp_q.push_back('{res: calc_fn(req_a, req_b, req_op), tag: req_tag});
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL rsp_unexpected: got tag %0h result %0h, expected no response", rsp_tag, rsp_result);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
            chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      flush = 1'b0;
      rsp_ready = 1'b0;
      reset_high = 1'b1;
      repeat (2) @(negedge clk);
      reset_high = 1'b0;
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{32'd5, 32'd7, 3'd0, 4'd3, 33'd12};
      vecs[1] = '{32'hFFFF_FFFF, 32'd1, 3'd0, 4'd9, 33'h1_0000_0000};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 4'd15, 33'h1_FFFF_FFFE};
      vecs[3] = '{32'd10, 32'd3, 3'd1, 4'd6, 33'd7};
      vecs[4] = '{32'hF0F0_0000, 32'h0FF0_1234, 3'd2, 4'd0, 33'h0_FF00_1234};
      vecs[5] = '{32'd0, 32'd0, 3'd0, 4'd10, 33'd0};
      #1 reset_high = 1'b1;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_result", 64'(rsp_result), 64'(0));
      chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
      chk("rst_calc_a", 64'(calc_a), 64'(0));
      chk("rst_calc_b", 64'(calc_b), 64'(0));
      chk("rst_calc_op", 64'(calc_opcode), 64'(0));
      chk("rst_flush_done", 64'(flush_done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_issue_cnt", 64'(issue_cnt), 64'(0));
      chk("rst_rsp_cnt", 64'(rsp_cnt), 64'(0));
      repeat (2) @(negedge clk);
      reset_high = 1'b0;
      @(negedge clk);
      // single requests: accept at t, calc inputs after t+1, response after t+2
      foreach (vecs[i]) begin
         req_valid = 1'b1;
         req_a = vecs[i].a;
         req_b = vecs[i].b;
         req_op = vecs[i].op;
         req_tag = vecs[i].tag;
         chk("vec_accept", 64'(req_ready), 64'(1));
         step();
         req_valid = 1'b0;
         chk("vec_busy", 64'(busy), 64'(1));
         step();
         chk("vec_calc_a", 64'(calc_a), 64'(vecs[i].a));
         chk("vec_calc_b", 64'(calc_b), 64'(vecs[i].b));
         chk("vec_calc_op", 64'(calc_opcode), 64'(vecs[i].op));
         chk("vec_early_rsp", 64'(rsp_valid), 64'(0));
         step();
         chk("vec_rsp_valid", 64'(rsp_valid), 64'(1));
         chk("vec_rsp_result", 64'(rsp_result), 64'(vecs[i].res));
         chk("vec_rsp_tag", 64'(rsp_tag), 64'(vecs[i].tag));
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         chk("vec_drained", 64'(rsp_valid), 64'(0));
         step();
         chk("vec_idle", 64'(busy), 64'(0));
      end
      // back-pressure: ten requests with responses blocked
      k = 0;
      n0 = n_rsp;
      for (int c = 0; c < 12; c++) begin
         req_valid = k < 10;
         req_a = 32'(k * 16 + 1);
         req_b = 32'(k);
         req_op = 3'd0;
         req_tag = TW'(k);
         acc = req_valid && req_ready;
         step();
         if (acc) k++;
      end
      chk("bp_accepted", 64'(k), 64'(REQ_DEPTH + RSP_DEPTH));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_last_issue", 64'(calc_a), 64'((RSP_DEPTH - 1) * 16 + 1));
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      rsp_ready = 1'b1;
      for (int c = 0; c < 60 && (k < 10 || exp_q.size() > 0); c++) begin
         req_valid = k < 10;
         req_a = 32'(k * 16 + 1);
         req_b = 32'(k);
         req_tag = TW'(k);
         acc = req_valid && req_ready;
         step();
         if (acc) k++;
      end
      req_valid = 1'b0;
      chk("bp_returned", 64'(n_rsp - n0), 64'(10));
      chk("bp_model_empty", 64'(exp_q.size()), 64'(0));
      // streaming: sixteen back-to-back requests from a fresh reset
      do_reset();
      rsp_ready = 1'b1;
      k = 0;
      n0 = n_rsp;
      first = -1;
      last = -1;
      done_at = -1;
      for (int c = 0; c < 60 && (k < 16 || exp_q.size() > 0); c++) begin
         req_valid = k < 16;
         req_a = 32'(1000 + k);
         req_b = 32'(k * 3);
         req_op = 3'(k % 3);
         req_tag = TW'(k);
         acc = req_valid && req_ready;
         hs = rsp_valid && rsp_ready;
         if (hs && first < 0) first = c;
         if (hs) last = c;
         step();
         if (acc) k++;
         if (acc && k == 16) done_at = c;
      end
      req_valid = 1'b0;
      chk("stream_accept_span", 64'(done_at), 64'(15));
      chk("stream_rsp_count", 64'(n_rsp - n0), 64'(16));
      chk("stream_rsp_span", 64'(last - first), 64'(15));
`ifdef CALC_SCHED_STATS_EN
      chk("stream_issue_cnt", 64'(issue_cnt), 64'(16));
      chk("stream_rsp_cnt", 64'(rsp_cnt), 64'(16));
`else
      chk("stream_issue_cnt", 64'(issue_cnt), 64'(0));
      chk("stream_rsp_cnt", 64'(rsp_cnt), 64'(0));
`endif
      // flush with three requests in the scheduler
      n0 = n_rsp;
      for (int c = 0; c < 3; c++) begin
         req_valid = 1'b1;
         req_a = 32'(100 + c);
         req_b = 32'(c);
         req_op = 3'd0;
         req_tag = TW'(c + 4);
         chk("fl_accept", 64'(req_ready), 64'(1));
         step();
      end
      req_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_req_ready", 64'(req_ready), 64'(0));
      chk("fl_busy", 64'(busy), 64'(1));
      k = 0;
      for (int c = 0; c < 20; c++) begin
         if (flush_done) k++;
         step();
      end
      chk("fl_pulses", 64'(k), 64'(1));
      chk("fl_rsp_count", 64'(n_rsp - n0), 64'(3));
      chk("fl_idle", 64'(busy), 64'(0));
      chk("fl_ready_again", 64'(req_ready), 64'(1));
      // flush while idle: immediate single pulse
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("idle_flush_done", 64'(flush_done), 64'(1));
      chk("idle_flush_busy", 64'(busy), 64'(0));
      step();
      chk("idle_flush_clear", 64'(flush_done), 64'(0));
      // asynchronous reset with work outstanding
      rsp_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         req_valid = 1'b1;
         req_a = 32'(7 + c);
         req_b = 32'(1);
         req_tag = TW'(c + 12);
         step();
      end
      req_valid = 1'b0;
      step();
      chk("mid_pre_valid", 64'(rsp_valid), 64'(1));
      #2 reset_high = 1'b1;
      #1;
      chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rsp_result", 64'(rsp_result), 64'(0));
      chk("mid_rsp_tag", 64'(rsp_tag), 64'(0));
      chk("mid_req_ready", 64'(req_ready), 64'(1));
      chk("mid_busy", 64'(busy), 64'(0));
      chk("mid_calc_a", 64'(calc_a), 64'(0));
      chk("mid_calc_op", 64'(calc_opcode), 64'(0));
      @(negedge clk);
      reset_high = 1'b0;
      exp_q.delete();
      rsp_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid) k++;
         step();
      end
      chk("mid_no_rsp", 64'(k), 64'(0));
      // random traffic against the queue model
      n0 = n_rsp;
      k = 0;
      for (int c = 0; c < 400; c++) begin
         req_valid = $urandom_range(0, 1) == 1;
         req_a = $urandom;
         req_b = $urandom;
         req_op = 3'($urandom_range(0, 2));
         req_tag = TW'($urandom);
         rsp_ready = $urandom_range(0, 9) < 7;
         if (req_valid && req_ready) k++;
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
      chk("rand_drained", 64'(exp_q.size()), 64'(0));
      chk("rand_rsp_count", 64'(n_rsp - n0), 64'(k));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
